// File: rtl/press_classifier_if.sv
// Signal bundle between a press_classifier instance and its consumer.
// master drives the raw button level; slave (the classifier) returns the conditioned events.
interface press_classifier_if;
    logic btn_raw;
    logic btn_level;
    logic press;
    logic short_pulse;
    logic long_pulse;
    logic held_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  press,
        input  short_pulse,
        input  long_pulse,
        input  held_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output press,
        output short_pulse,
        output long_pulse,
        output held_long
    );
endinterface

// File: rtl/press_classifier.sv
// Button conditioning: 2-flop sync, debounce, short/long press classification with one-cycle pulses.
// Optional auto-repeat of long_pulse while held is enabled by defining PRESS_REPEAT_EN.
module press_classifier #(
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int LONG_CYCLES   = 200_000_000,
    parameter int REPEAT_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    press_classifier_if.slave btn_if
);
    localparam int DCNT_W = $clog2(DEB_CYCLES);
    localparam int HCNT_W = $clog2(LONG_CYCLES) + 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_LONG
    } state_t;

    // Elaboration-time sanity check on the timing parameters.
    if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES || REPEAT_CYCLES < 1) begin : g_param_check
        $error("press_classifier: invalid DEB_CYCLES/LONG_CYCLES/REPEAT_CYCLES");
    end

    logic [1:0]        sync_q;
    logic              s;
    logic              level_q, level_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              rise, fall;

    state_t            state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              press_q, press_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              held_q, held_d;
    logic              rpt_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_if.btn_raw};
        end
    end

    assign s = sync_q[1];

    // A level change is accepted only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        dcnt_d  = '0;
        level_d = level_q;
        rise    = 1'b0;
        fall    = 1'b0;
        if (s != level_q) begin
            if (dcnt_q == DCNT_LAST) begin
                level_d = s;
                rise    = s;
                fall    = ~s;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
        end
    end

`ifdef PRESS_REPEAT_EN
    localparam int RCNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;

    // Counter sits at zero outside LONG, so it restarts from 0 on every entry.
    always_comb begin
        rcnt_d   = '0;
        rpt_fire = 1'b0;
        if (state_q == ST_LONG && !fall) begin
            if (rcnt_q == RCNT_LAST) begin
                rpt_fire = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Fall is tested before the long threshold so a coincident release stays a short press.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        press_d = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hcnt_d = '0;
                if (rise) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (hcnt_q != HCNT_MAX) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
                if (fall) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end else if (hcnt_q == HCNT_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (rpt_fire) begin
                    long_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        held_d = (state_d == ST_LONG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            press_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            press_q <= press_d;
            short_q <= short_d;
            long_q  <= long_d;
            held_q  <= held_d;
        end
    end

    assign btn_if.btn_level   = level_q;
    assign btn_if.press       = press_q;
    assign btn_if.short_pulse = short_q;
    assign btn_if.long_pulse  = long_q;
    assign btn_if.held_long   = held_q;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with DEB=4, LONG=20, REPEAT=8.
// Expected timings are hand-derived from the raw edge (edge E0 = edge after which btn_raw changes).
module tb_press_classifier;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int RPT  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    press_classifier_if bus ();

    press_classifier #(
        .DEB_CYCLES    (DEB),
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (RPT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_if (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int n_press = 0, n_short = 0, n_long = 0, n_overlap = 0;
    int last_press_cyc = 0, last_long_cyc = 0;
    always @(negedge clk) begin
        if (bus.press === 1'b1) begin
            n_press        <= n_press + 1;
            last_press_cyc <= cyc;
        end
        if (bus.short_pulse === 1'b1) n_short <= n_short + 1;
        if (bus.long_pulse === 1'b1) begin
            n_long        <= n_long + 1;
            last_long_cyc <= cyc;
        end
        if (int'(bus.press) + int'(bus.short_pulse) + int'(bus.long_pulse) > 1)
            n_overlap <= n_overlap + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int b_press, b_short, b_long;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_press = n_press;
        b_short = n_short;
        b_long  = n_long;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, 32'(bus.btn_level), 0);
        check({tag, "_press"}, 32'(bus.press), 0);
        check({tag, "_short"}, 32'(bus.short_pulse), 0);
        check({tag, "_long"},  32'(bus.long_pulse), 0);
        check({tag, "_held"},  32'(bus.held_long), 0);
    endtask

    initial begin
        bus.btn_raw = 1'b0;
        rst = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(3);

        // Clean press held 10 cycles.
        snap();
        bus.btn_raw = 1'b1;
        tick(5);  check("clean_lvl_e5", 32'(bus.btn_level), 0);
        tick(1);  check("clean_lvl_e6", 32'(bus.btn_level), 1);
                  check("clean_press_e6", 32'(bus.press), 1);
        tick(1);  check("clean_press_e7", 32'(bus.press), 0);
        tick(3);  bus.btn_raw = 1'b0;
        tick(5);  check("clean_lvl_f5", 32'(bus.btn_level), 1);
                  check("clean_short_f5", 32'(bus.short_pulse), 0);
        tick(1);  check("clean_lvl_f6", 32'(bus.btn_level), 0);
                  check("clean_short_f6", 32'(bus.short_pulse), 1);
        tick(1);  check("clean_short_f7", 32'(bus.short_pulse), 0);
        tick(4);
        check("clean_npress", 32'(n_press - b_press), 1);
        check("clean_nshort", 32'(n_short - b_short), 1);
        check("clean_nlong",  32'(n_long - b_long), 0);

        // Bounce 1-0-1-0 (2 cycles each) then steady high.
        snap();
        bus.btn_raw = 1'b1; tick(2);
        bus.btn_raw = 1'b0; tick(2);
        bus.btn_raw = 1'b1; tick(2);
        bus.btn_raw = 1'b0; tick(2);
        check("bounce_lvl_mid", 32'(bus.btn_level), 0);
        bus.btn_raw = 1'b1;
        tick(5);  check("bounce_lvl_e5", 32'(bus.btn_level), 0);
        tick(1);  check("bounce_lvl_e6", 32'(bus.btn_level), 1);
                  check("bounce_press_e6", 32'(bus.press), 1);
        tick(4);  bus.btn_raw = 1'b0;
        tick(10);
        check("bounce_npress", 32'(n_press - b_press), 1);
        check("bounce_nshort", 32'(n_short - b_short), 1);
        check("bounce_nlong",  32'(n_long - b_long), 0);

        // Hold 40 cycles: long press (with repeats when enabled).
        snap();
        bus.btn_raw = 1'b1;
        tick(6);  check("hold_press_e6", 32'(bus.press), 1);
        tick(19); check("hold_long_e25", 32'(bus.long_pulse), 0);
                  check("hold_held_e25", 32'(bus.held_long), 0);
        tick(1);  check("hold_long_e26", 32'(bus.long_pulse), 1);
                  check("hold_held_e26", 32'(bus.held_long), 1);
        tick(1);  check("hold_long_e27", 32'(bus.long_pulse), 0);
                  check("hold_long_dist", 32'(last_long_cyc - last_press_cyc), LONG);
        tick(7);
`ifdef PRESS_REPEAT_EN
        check("hold_long_e34", 32'(bus.long_pulse), 1);
`else
        check("hold_long_e34", 32'(bus.long_pulse), 0);
`endif
        tick(6);  bus.btn_raw = 1'b0;
        tick(2);
`ifdef PRESS_REPEAT_EN
        check("hold_long_e42", 32'(bus.long_pulse), 1);
`else
        check("hold_long_e42", 32'(bus.long_pulse), 0);
`endif
        check("hold_held_e42", 32'(bus.held_long), 1);
        tick(3);  check("hold_lvl_e45", 32'(bus.btn_level), 1);
                  check("hold_held_e45", 32'(bus.held_long), 1);
        tick(1);  check("hold_lvl_e46", 32'(bus.btn_level), 0);
                  check("hold_held_e46", 32'(bus.held_long), 0);
                  check("hold_short_e46", 32'(bus.short_pulse), 0);
                  check("hold_long_e46", 32'(bus.long_pulse), 0);
        tick(8);
        check("hold_npress", 32'(n_press - b_press), 1);
        check("hold_nshort", 32'(n_short - b_short), 0);
`ifdef PRESS_REPEAT_EN
        check("hold_nlong", 32'(n_long - b_long), 3);
`else
        check("hold_nlong", 32'(n_long - b_long), 1);
`endif

        // Release timed so the debounced fall lands on the long threshold.
        snap();
        bus.btn_raw = 1'b1;
        tick(20); bus.btn_raw = 1'b0;
        tick(5);  check("tie_lvl_e25", 32'(bus.btn_level), 1);
                  check("tie_short_e25", 32'(bus.short_pulse), 0);
        tick(1);  check("tie_lvl_e26", 32'(bus.btn_level), 0);
                  check("tie_short_e26", 32'(bus.short_pulse), 1);
                  check("tie_long_e26", 32'(bus.long_pulse), 0);
                  check("tie_held_e26", 32'(bus.held_long), 0);
        tick(5);
        check("tie_nshort", 32'(n_short - b_short), 1);
        check("tie_nlong",  32'(n_long - b_long), 0);

        // Reset while in LONG with the button still held.
        snap();
        bus.btn_raw = 1'b1;
        tick(30); check("rst_held_pre", 32'(bus.held_long), 1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        tick(3);
        check_all_zero("rst_hold");
        rst = 1'b0;
        tick(5);  check("rst_lvl_e5", 32'(bus.btn_level), 0);
                  check("rst_press_e5", 32'(bus.press), 0);
        tick(1);  check("rst_lvl_e6", 32'(bus.btn_level), 1);
                  check("rst_press_e6", 32'(bus.press), 1);
        tick(1);  check("rst_press_e7", 32'(bus.press), 0);
        bus.btn_raw = 1'b0;
        tick(10);
        check("rst_npress", 32'(n_press - b_press), 2);
        check("rst_nshort", 32'(n_short - b_short), 1);

        check("pulse_overlap", 32'(n_overlap), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/press_classifier.md
# press_classifier

Per-button input conditioning stage sitting between a raw board push-button (or the active-low goal sensor, inverted before entry) and the game FSM/VGA/7-segment logic. Synchronises and debounces the raw input on the system clock, then classifies each press as short or long and emits single-cycle event pulses. One instance per button; it replaces the separate debounce, one-pulse and long-press chain with a single clock domain and no derived clocks.

## Interface

Parameters:
- `DEB_CYCLES`, 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); minimum 2.
- `LONG_CYCLES`, 200_000_000: hold duration, in cycles from debounced rise, that classifies a press as long (2 s); must exceed `DEB_CYCLES`.
- `REPEAT_CYCLES`, 50_000_000: auto-repeat period after a long press (only used with `PRESS_REPEAT_EN`).

Ports:
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: asynchronous, active-high reset.
- `btn_raw` in 1: asynchronous raw button level, active-high.
- `btn_level` out 1: debounced level.
- `press` out 1: one-cycle pulse on debounced rise.
- `short_pulse` out 1: one-cycle pulse on debounced fall when the press never reached long.
- `long_pulse` out 1: one-cycle pulse when hold reaches `LONG_CYCLES` (plus repeats if enabled).
- `held_long` out 1: high from `long_pulse` until debounced fall.

## Operation

- Synchroniser: two flops, `s = btn_raw` delayed 2 cycles; reset to 0.
- Debounce counter `dcnt` (width `$clog2(DEB_CYCLES)`): cleared whenever `s == btn_level`; increments while `s != btn_level`; when `dcnt == DEB_CYCLES-1` and `s != btn_level`, `btn_level` toggles on the next edge and `dcnt` clears. Any glitch back to the current level before expiry restarts the count.
- Hold counter `hcnt` (width `$clog2(LONG_CYCLES)+1`): cleared in IDLE; increments every cycle in PRESSED; saturates, never wraps.
- FSM, states IDLE, PRESSED, LONG; reset state IDLE.
  - IDLE -> PRESSED on debounced rise; `press`=1 that cycle.
  - PRESSED -> LONG when `hcnt == LONG_CYCLES-1`; `long_pulse`=1, `held_long`=1.
  - PRESSED -> IDLE on debounced fall; `short_pulse`=1.
  - LONG -> IDLE on debounced fall; no `short_pulse`; `held_long`=0.
- Fall and long-threshold in the same cycle: fall wins, `short_pulse` only.
- All outputs registered; at most one of `press`/`short_pulse`/`long_pulse` high in any cycle.

## Timing

- Reset values: `btn_level`, `press`, `short_pulse`, `long_pulse`, `held_long` all 0; counters 0; FSM IDLE. Reset mid-press returns to IDLE with no pulses; a still-held button after release of reset is re-debounced and produces a fresh `press`.
- Raw edge to `btn_level` change: exactly 2 + `DEB_CYCLES` cycles for a clean edge.
- `press` and `btn_level` rise in the same cycle; `short_pulse` and `btn_level` fall in the same cycle.
- `long_pulse` asserted `LONG_CYCLES` cycles after the `press` cycle (press at cycle N, long at N+LONG_CYCLES).
- Pulses are exactly one `clk` cycle wide.

## Configuration

- `PRESS_REPEAT_EN` defined: in LONG, a repeat counter runs from 0; each time it reaches `REPEAT_CYCLES-1` it clears and `long_pulse` fires again, until debounced fall. Repeat counter cleared on entry to LONG and on reset.
- Not defined: exactly one `long_pulse` per press; no repeat counter logic synthesised; `REPEAT_CYCLES` ignored.

## Test plan

Bench parameters: `DEB_CYCLES`=4, `LONG_CYCLES`=20, `REPEAT_CYCLES`=8.
- Clean press held 10 cycles then released -> `btn_level` rises 6 cycles after raw rise with `press`; `short_pulse` on fall 6 cycles after raw fall; no `long_pulse`.
- Raw bounce 1-0-1-0 each 2 cycles then steady high -> exactly one `press`, rising 6 cycles after the final stable edge; no extra pulses.
- Hold 40 cycles, macro undefined -> `long_pulse` exactly 20 cycles after `press`, `held_long` high until fall, no `short_pulse` on release.
- Hold 40 cycles, `PRESS_REPEAT_EN` defined -> `long_pulse` at press+20, +28, +36; none after fall.
- Raw release timed so debounced fall coincides with `hcnt`=19 -> `short_pulse` only, `long_pulse` stays 0.
- Assert `rst` for 3 cycles while in LONG with raw held -> all outputs 0 during reset; after release a new `press` appears 6 cycles later.
